idli_urx_m: RTL
===============

IDLI_URX_M -- requirements
Module: idli_urx_m

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning gck cycles per UART bit period (even, >= 4).
REQ-002 The block SHALL have port i_urx_gck  input  1  core clock; all state on its rising edge.
REQ-003 The block SHALL have port i_top_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_urx_ctr  input  2  core slice counter; 0..3 selects the slice position.
REQ-005 The block SHALL have port i_urx_rx  input  1  UART serial line; idle high; asynchronous to gck.
REQ-006 The block SHALL have port o_urx_data  output  4  received data slice to the core.
REQ-007 The block SHALL have port o_urx_vld  output  1  at least one received byte is buffered.
REQ-008 The block SHALL have port i_urx_acp  input  1  core accepts a 16-bit transfer.
REQ-009 The block SHALL have port o_urx_ferr  output  1  one-cycle pulse on framing or parity error.
REQ-010 The block SHALL have port o_urx_ovf  output  1  sticky overflow flag; a byte was dropped because the FIFO was full.

Function
REQ-011 i_urx_rx SHALL pass through a 2-flop synchronizer, reset value 1; all FSM decisions SHALL use the synchronized value.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (present only with parity enabled), STOP and WAIT_HI.
REQ-013 IDLE: a synchronized 0 SHALL enter START and load the bit timer with CLKS_PER_BIT/2-1.
REQ-014 START: on timer expiry, 1 SHALL return to IDLE (glitch, no error); 0 SHALL enter DATA with timer CLKS_PER_BIT-1 and bit index 0.
REQ-015 DATA: every timer expiry SHALL sample one bit into the shift register, LSB first; after bit 7 the FSM SHALL enter PARITY if enabled, else STOP.
REQ-016 STOP: on expiry, 1 SHALL push the byte and return to IDLE; 0 SHALL pulse o_urx_ferr, drop the byte and enter WAIT_HI.
REQ-017 WAIT_HI SHALL remain until a synchronized 1 is seen, then enter IDLE.
REQ-018 The FIFO SHALL be 2 entries of 8 bits; o_urx_vld SHALL be 1 the cycle after a push into an empty FIFO.
REQ-019 A push into a full FIFO SHALL drop the byte, leave FIFO contents unchanged and set o_urx_ovf until reset.
REQ-020 A transfer SHALL start only in a cycle with i_urx_ctr==0, o_urx_vld==1 and i_urx_acp==1; i_urx_acp SHALL be ignored when i_urx_ctr!=0.
REQ-021 During a transfer, o_urx_data SHALL be head[3:0] at ctr 0, head[7:4] at ctr 1, and 0 at ctr 2 and 3 (zero-extended 16-bit value, LSB slice first).
REQ-022 The head SHALL pop at the end of the ctr==3 cycle of a transfer; o_urx_vld SHALL stay high for the entire transfer.
REQ-023 o_urx_data SHALL be 0 outside a transfer.
REQ-024 A push and a pop in the same cycle SHALL both occur; the occupancy is unchanged and a full FIFO does not overflow.
REQ-025 Reception SHALL continue regardless of core stalls; only FIFO occupancy limits buffering.

Reset
REQ-026 Asserting i_top_rst_n low at any time, including mid-frame or mid-transfer, SHALL force the following on the next rising edge of gck:
- FSM to IDLE, synchronizer to 1, FIFO empty, transfer aborted;
- o_urx_data=0, o_urx_vld=0, o_urx_ferr=0, o_urx_ovf=0.
REQ-027 After reset release, a line already low SHALL be treated as a start edge.

Configuration
REQ-028 Macro IDLI_URX_PARITY_EN defined: the frame SHALL carry an even parity bit after data bit 7, sampled in PARITY. A mismatch SHALL pulse o_urx_ferr and drop the byte. The FSM then continues to STOP; a low stop bit in that frame SHALL NOT produce a second pulse.
REQ-029 Macro IDLI_URX_PARITY_EN undefined: the frame SHALL be 8N1, with no PARITY state or parity logic.

Verification (CLKS_PER_BIT=4, no parity unless stated)
REQ-030 Send 0xA5 with the core idle, then acp at ctr0. Required: o_urx_vld rises; o_urx_data is 5,A,0,0 over ctr 0..3; o_urx_vld falls after ctr 3.
REQ-031 Send 0x11, 0x22 and 0x33 with no acp. Required: o_urx_ovf=1; two transfers then return 0x11 then 0x22, and the FIFO is empty.
REQ-032 Send 0x3C with the stop bit driven 0, and hold the line low for 20 cycles. Required: one o_urx_ferr pulse; no push; the FSM waits in WAIT_HI; a following 0x01 is received correctly.
REQ-033 Drive a 1-cycle low glitch on an idle line. Required: no push and no o_urx_ferr.
REQ-034 Assert reset mid data bit 4 while one byte is buffered. Required: all outputs 0; a subsequent 0x7E is received correctly.
REQ-035 With IDLI_URX_PARITY_EN, send 0x03 with parity bit 1. Required: one o_urx_ferr pulse and no push. Send 0x03 with parity 0. Required: received as 0x03.

Source files
------------

// File: rtl/idli_urx_m.sv
// ---------------------------------------------------------------------------
// idli_urx_m -- UART receiver for the idli core
//
// Receives 8-bit UART frames on an asynchronous serial line, buffers up to
// two bytes in a small FIFO and hands each byte to the core as a 16-bit
// zero-extended value, one 4-bit slice per core slice-counter position.
//
// Build option:
//   IDLI_URX_PARITY_EN  defined   -> 8E1 frames: an even parity bit follows
//                                    data bit 7.
//                       undefined -> 8N1 frames with no parity logic (default).
//
// Parameters:
//   CLKS_PER_BIT  gck cycles per UART bit period (even, >= 4), default 16
//
// Ports:
//   i_urx_gck    in   1  core clock, all state on its rising edge
//   i_top_rst_n  in   1  asynchronous active-low reset
//   i_urx_ctr    in   2  core slice counter, 0..3 selects the slice position
//   i_urx_rx     in   1  UART serial line, idle high, asynchronous to gck
//   o_urx_data   out  4  received data slice to the core
//   o_urx_vld    out  1  at least one received byte is buffered
//   i_urx_acp    in   1  core accepts a 16-bit transfer (sampled at ctr 0)
//   o_urx_ferr   out  1  one-cycle pulse on a framing or parity error
//   o_urx_ovf    out  1  sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module idli_urx_m #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_urx_gck,
  input  logic       i_top_rst_n,
  input  logic [1:0] i_urx_ctr,
  input  logic       i_urx_rx,
  output logic [3:0] o_urx_data,
  output logic       o_urx_vld,
  input  logic       i_urx_acp,
  output logic       o_urx_ferr,
  output logic       o_urx_ovf
);

  // Bit timer is wide enough to hold CLKS_PER_BIT-1.
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

`ifdef IDLI_URX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;
`endif

  // -------------------------------------------------------------------------
  // Receive path signals
  // -------------------------------------------------------------------------
  logic          rx_meta;
  logic          rx_sync;
  state_t        state;
  logic [TW-1:0] bit_tmr;
  logic          tmr_done;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          push_req;
  logic          ferr_q;
`ifdef IDLI_URX_PARITY_EN
  logic          par_err;
`endif

  // -------------------------------------------------------------------------
  // FIFO / transfer signals
  // -------------------------------------------------------------------------
  logic [7:0]    fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          fifo_full;
  logic          xfer_act;
  logic          xfer_start;
  logic          pop;
  logic          do_push;
  logic          ovf_q;
  logic [7:0]    head;

  // The serial line is asynchronous to gck, so it goes through two flops
  // before anything looks at it. Reset to 1 so reset never fakes a start bit;
  // a line already low after reset still shows up as a start edge two cycles
  // later.
  always_ff @(posedge i_urx_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_urx_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tmr_done = (bit_tmr == '0);

  // Frame receiver. START waits half a bit so every later sample lands in
  // the middle of its bit; a line that is high again at that point was a
  // glitch and is silently ignored. push_req and ferr_q are single-cycle
  // registered pulses. A frame whose stop bit is low parks in WAIT_HI so a
  // stuck-low line cannot be mistaken for a stream of start bits.
  always_ff @(posedge i_urx_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      state    <= S_IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      push_req <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef IDLI_URX_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      ferr_q   <= 1'b0;

      // Count down in every timed state; an expiry below reloads the timer.
      if ((state != S_IDLE) && (state != S_WAIT_HI) && !tmr_done) begin
        bit_tmr <= bit_tmr - 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state   <= S_START;
            bit_tmr <= HALF_LOAD;
          end
        end

        S_START: begin
          if (tmr_done) begin
            if (rx_sync) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_tmr <= FULL_LOAD;
              bit_idx <= '0;
`ifdef IDLI_URX_PARITY_EN
              par_err <= 1'b0;
`endif
            end
          end
        end

        S_DATA: begin
          if (tmr_done) begin
            // LSB arrives first, so shift in from the top.
            shift_q <= {rx_sync, shift_q[7:1]};
            bit_tmr <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef IDLI_URX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end

`ifdef IDLI_URX_PARITY_EN
        S_PARITY: begin
          if (tmr_done) begin
            bit_tmr <= FULL_LOAD;
            state   <= S_STOP;
            // Even parity: the parity bit equals the XOR of the data bits.
            if (rx_sync != ^shift_q) begin
              ferr_q  <= 1'b1;
              par_err <= 1'b1;
            end
          end
        end
`endif

        S_STOP: begin
          if (tmr_done) begin
            if (rx_sync) begin
              state <= S_IDLE;
`ifdef IDLI_URX_PARITY_EN
              push_req <= !par_err;
`else
              push_req <= 1'b1;
`endif
            end else begin
              state <= S_WAIT_HI;
              // A frame already flagged for bad parity reports only once.
`ifdef IDLI_URX_PARITY_EN
              ferr_q <= !par_err;
`else
              ferr_q <= 1'b1;
`endif
            end
          end
        end

        S_WAIT_HI: begin
          if (rx_sync) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Core-side transfer control
  // -------------------------------------------------------------------------
  // A transfer begins only at slice 0 with data available and the core
  // accepting; acp at any other slice is ignored. The head byte is popped on
  // the last slice, so vld stays high for the whole transfer.
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign xfer_start = (i_urx_ctr == 2'd0) && (fifo_cnt != 2'd0) &&
                      i_urx_acp && !xfer_act;
  assign pop        = xfer_act && (i_urx_ctr == 2'd3);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_req && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr];

  // Two-entry FIFO with occupancy counter, the sticky overflow flag and the
  // transfer-active flag. When full, wr_ptr equals rd_ptr; a simultaneous
  // push and pop therefore overwrites exactly the slot being released.
  always_ff @(posedge i_urx_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
      ovf_q    <= 1'b0;
      xfer_act <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= shift_q;
        wr_ptr           <= ~wr_ptr;
      end

      if (push_req && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (xfer_start) begin
        xfer_act <= 1'b1;
      end else if (pop) begin
        xfer_act <= 1'b0;
      end
    end
  end

  // Slice mux: the slice-0 nibble must already be on the bus in the cycle
  // the core accepts, hence xfer_start as well as xfer_act. The upper two
  // slices are the zero extension of the byte.
  always_comb begin
    o_urx_data = 4'h0;
    if (xfer_act || xfer_start) begin
      case (i_urx_ctr)
        2'd0:    o_urx_data = head[3:0];
        2'd1:    o_urx_data = head[7:4];
        default: o_urx_data = 4'h0;
      endcase
    end
  end

  assign o_urx_vld  = (fifo_cnt != 2'd0);
  assign o_urx_ferr = ferr_q;
  assign o_urx_ovf  = ovf_q;

endmodule
